// File: rtl/max_scan_seq.sv
// Sequential max-finder: snapshots N words and scans them one per cycle through a single
// wrap-aware comparator, reporting the winning word and its index with a done pulse.
module max_scan_seq #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned N     = 8,
   parameter int unsigned IDX_W = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [N*WIDTH-1:0]   in_data,
   output logic                 ready,
   output logic                 done,
   output logic [WIDTH-1:0]     max_out,
   output logic [IDX_W-1:0]     max_idx
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StScan = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [IDX_W-1:0] FirstPtr = IDX_W'(1);
   localparam logic [IDX_W-1:0] LastPtr  = IDX_W'(N - 1);

   logic [1:0]         state_q, state_d;
   logic [N*WIDTH-1:0] snap_q, snap_d;
   logic [WIDTH-1:0]   best_q, best_d;
   logic [IDX_W-1:0]   best_idx_q, best_idx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0]   max_out_q, max_out_d;
   logic [IDX_W-1:0]   max_idx_q, max_idx_d;

   logic [WIDTH-1:0]   cand;
   logic [WIDTH-1:0]   diff;
   logic               cand_wins;

   always_comb begin
      cand = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (ptr_q == IDX_W'(i)) begin
            cand = snap_q[i*WIDTH +: WIDTH];
         end
      end
   end

   // Half-range compare: candidate wins when it is at most 2^(WIDTH-1)-1 ahead (ties win).
   assign diff      = cand - best_q;
   assign cand_wins = ~diff[WIDTH-1];

   always_comb begin
      state_d    = state_q;
      snap_d     = snap_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      ptr_d      = ptr_q;
      max_out_d  = max_out_q;
      max_idx_d  = max_idx_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               snap_d     = in_data;
               best_d     = in_data[WIDTH-1:0];
               best_idx_d = '0;
               ptr_d      = FirstPtr;
               if (N == 1) begin
                  state_d   = StDone;
                  max_out_d = in_data[WIDTH-1:0];
                  max_idx_d = '0;
               end else begin
                  state_d = StScan;
               end
            end
         end
         StScan: begin
            if (cand_wins) begin
               best_d     = cand;
               best_idx_d = ptr_q;
            end
            if (ptr_q == LastPtr) begin
               state_d   = StDone;
               max_out_d = best_d;
               max_idx_d = best_idx_d;
            end else begin
               ptr_d = ptr_q + FirstPtr;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         snap_q     <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         ptr_q      <= '0;
         max_out_q  <= '0;
         max_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         snap_q     <= snap_d;
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         ptr_q      <= ptr_d;
         max_out_q  <= max_out_d;
         max_idx_q  <= max_idx_d;
      end
   end

   assign ready   = (state_q == StIdle);
   assign done    = (state_q == StDone);
   assign max_out = max_out_q;
   assign max_idx = max_idx_q;

endmodule

// File: tb/tb_max_scan_seq.sv
// Scoreboard bench for max_scan_seq: an N=4 and an N=1 instance, directed vectors with
// hand-computed results queued at issue time and checked by per-instance done monitors.
module tb_max_scan_seq;

   localparam int W  = 10;
   localparam int N4 = 4;

   typedef struct {
      int val;
      int idx;
      int cyc;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          start4, start1;
   logic [4*W-1:0] in4;
   logic [W-1:0]  in1;
   logic          ready4, done4, ready1, done1;
   logic [W-1:0]  max4, max1;
   logic [1:0]    idx4;
   logic [0:0]    idx1;

   exp_t q4[$];
   exp_t q1[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   max_scan_seq #(.WIDTH(W), .N(4), .IDX_W(2)) u_dut4 (
      .clock   (clock),
      .reset   (reset),
      .start   (start4),
      .in_data (in4),
      .ready   (ready4),
      .done    (done4),
      .max_out (max4),
      .max_idx (idx4)
   );

   max_scan_seq #(.WIDTH(W), .N(1), .IDX_W(1)) u_dut1 (
      .clock   (clock),
      .reset   (reset),
      .start   (start1),
      .in_data (in1),
      .ready   (ready1),
      .done    (done1),
      .max_out (max1),
      .max_idx (idx1)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic logic [4*W-1:0] pack4(input int a, input int b, input int c, input int d);
      return {W'(d), W'(c), W'(b), W'(a)};
   endfunction

   // Monitors: every done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      exp_t e;
      if (done4 === 1'b1) begin
         if (q4.size() == 0) begin
            check("dut4 unexpected done", 1, 0);
         end else begin
            e = q4.pop_front();
            check("dut4 max_out", int'(max4), e.val);
            check("dut4 max_idx", int'(idx4), e.idx);
            check("dut4 done cycle", cyc, e.cyc);
         end
      end
   end

   always @(negedge clock) begin
      exp_t e;
      if (done1 === 1'b1) begin
         if (q1.size() == 0) begin
            check("dut1 unexpected done", 1, 0);
         end else begin
            e = q1.pop_front();
            check("dut1 max_out", int'(max1), e.val);
            check("dut1 max_idx", int'(idx1), e.idx);
            check("dut1 done cycle", cyc, e.cyc);
         end
      end
   end

   task automatic run4(input logic [4*W-1:0] data, input int val, input int idx);
      q4.push_back('{val: val, idx: idx, cyc: cyc + N4});
      in4    = data;
      start4 = 1'b1;
      @(posedge clock); #1;
      start4 = 1'b0;
      check("dut4 ready low in scan", int'(ready4), 0);
      repeat (N4) @(posedge clock);
      #1;
      check("dut4 ready after done", int'(ready4), 1);
      check("dut4 max_out holds", int'(max4), val);
   endtask

   initial begin
      int vals[6];
      vals   = '{500, 1, 1023, 2, 300, 3};
      start4 = 1'b0;
      start1 = 1'b0;
      in4    = '0;
      in1    = '0;
      reset  = 1'b0;
      #1 reset = 1'b1;
      #2;
      // Reset must act before any clock edge.
      check("reset ready", int'(ready4), 1);
      check("reset done", int'(done4), 0);
      check("reset max_out", int'(max4), 0);
      check("reset max_idx", int'(idx4), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;

      run4(pack4(5, 300, 12, 7), 300, 1);
      run4(pack4(9, 9, 3, 9), 9, 3);
      run4(pack4(1020, 3, 1000, 2), 3, 1);

      // start held through SCAN and DONE with in_data changed after the start edge.
      q4.push_back('{val: 200, idx: 2, cyc: cyc + N4});
      in4    = pack4(100, 50, 200, 150);
      start4 = 1'b1;
      @(posedge clock); #1;
      in4 = pack4(900, 901, 902, 903);
      repeat (4) @(posedge clock);
      #1;
      start4 = 1'b0;
      check("dut4 idle after ignored starts", int'(ready4), 1);
      repeat (2) @(posedge clock);
      #1;
      check("dut4 hold after ignored starts", int'(max4), 200);

      // Abort mid-scan with an asynchronous reset.
      in4    = pack4(600, 601, 602, 603);
      start4 = 1'b1;
      @(posedge clock); #1;
      start4 = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      check("abort ready", int'(ready4), 1);
      check("abort done", int'(done4), 0);
      check("abort max_out", int'(max4), 0);
      check("abort max_idx", int'(idx4), 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock); #1;
      run4(pack4(1, 2, 3, 4), 4, 3);

      // N=1 instance: single scan, then back-to-back starts every other cycle.
      q1.push_back('{val: 77, idx: 0, cyc: cyc + 1});
      in1    = W'(77);
      start1 = 1'b1;
      @(posedge clock); #1;
      start1 = 1'b0;
      check("dut1 ready low in done", int'(ready1), 0);
      @(posedge clock); #1;
      check("dut1 ready after done", int'(ready1), 1);

      for (int j = 0; j < 6; j++) begin
         in1    = W'(vals[j]);
         start1 = 1'b1;
         if (j % 2 == 0) q1.push_back('{val: vals[j], idx: 0, cyc: cyc + 1});
         @(posedge clock); #1;
      end
      start1 = 1'b0;

      repeat (6) @(posedge clock);
      #1;
      check("dut4 outstanding results", q4.size(), 0);
      check("dut1 outstanding results", q1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
